// File: rtl/butterfly_dmem_resp_if.sv
// Data-memory bus between the ButterFly core (master) and its memory responder (slave).
interface butterfly_dmem_resp_if;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output valid, we, addr, wdata, wstrb, input rdata, ready, err);
    modport slave  (input valid, we, addr, wdata, wstrb, output rdata, ready, err);
endinterface

// File: rtl/butterfly_dmem_resp.sv
// Word-organised data RAM responder with byte strobes, programmable wait states
// and an out-of-range error flag that qualifies ready.
module butterfly_dmem_resp #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    butterfly_dmem_resp_if.slave  dmem
);

    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
    localparam logic [3:0]  WS_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               in_range_q;
    logic [31:0]        rdata_q;
    logic [31:0]        mem [DEPTH];

    logic [31:0]        offset;
    logic               in_range;
    logic               accept;
    logic               enter_resp;
    logic               req_we;
    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        req_wdata;
    logic [3:0]         req_wstrb;
    logic               req_in_range;

    // Unsigned wrap makes addresses below BASE_ADDR huge, so they never alias into range.
    assign offset   = dmem.addr - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign accept   = (state_q == S_IDLE) && dmem.valid;

    // With zero wait states RESP is entered on the accept edge, before the latches hold the request.
    always_comb begin
        if (state_q == S_IDLE) begin
            req_we       = dmem.we;
            req_idx      = offset[IDX_W+1:2];
            req_wdata    = dmem.wdata;
            req_wstrb    = dmem.wstrb;
            req_in_range = in_range;
        end else begin
            req_we       = we_q;
            req_idx      = idx_q;
            req_wdata    = wdata_q;
            req_wstrb    = wstrb_q;
            req_in_range = in_range_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dmem.valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!dmem.valid) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                if (!req_in_range) begin
                    rdata_q <= 32'd0;
                end else if (!req_we) begin
                    rdata_q <= mem[req_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q       <= dmem.we;
            idx_q      <= offset[IDX_W+1:2];
            wdata_q    <= dmem.wdata;
            wstrb_q    <= dmem.wstrb;
            in_range_q <= in_range;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enter_resp && !rst_i && req_we && req_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign dmem.rdata = rdata_q;
    assign dmem.ready = (state_q == S_RESP);
    assign dmem.err   = (state_q == S_RESP) && !in_range_q;

endmodule

// File: tb/tb_butterfly_dmem_resp.sv
// Directed bench for butterfly_dmem_resp: three instances with 0, 3 and 4 wait states share one bus driver.
module tb_butterfly_dmem_resp;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] TOP   = BASE + 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        v, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          sel;
    logic        rdy, errs;
    logic [31:0] rd;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    butterfly_dmem_resp_if bus0 ();
    butterfly_dmem_resp_if bus3 ();
    butterfly_dmem_resp_if bus4 ();

    assign bus0.valid = v && (sel == 0);
    assign bus3.valid = v && (sel == 1);
    assign bus4.valid = v && (sel == 2);
    assign bus0.we = we;    assign bus3.we = we;    assign bus4.we = we;
    assign bus0.addr = addr; assign bus3.addr = addr; assign bus4.addr = addr;
    assign bus0.wdata = wdata; assign bus3.wdata = wdata; assign bus4.wdata = wdata;
    assign bus0.wstrb = wstrb; assign bus3.wstrb = wstrb; assign bus4.wstrb = wstrb;

    butterfly_dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0))
        u_ws0 (.clk_i(clk), .rst_i(rst), .dmem(bus0));
    butterfly_dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3))
        u_ws3 (.clk_i(clk), .rst_i(rst), .dmem(bus3));
    butterfly_dmem_resp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(4))
        u_ws4 (.clk_i(clk), .rst_i(rst), .dmem(bus4));

    always_comb begin
        rdy  = bus0.ready;
        errs = bus0.err;
        rd   = bus0.rdata;
        case (sel)
            1: begin rdy = bus3.ready; errs = bus3.err; rd = bus3.rdata; end
            2: begin rdy = bus4.ready; errs = bus4.err; rd = bus4.rdata; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for ready, then confirm ready is a one-cycle pulse.
    task automatic xfer(input string tag, input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st, input int exp_lat);
        int n;
        sel = s; we = w; addr = a; wdata = d; wstrb = st; v = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!rdy && n < 50);
        v = 1'b0;
        last_lat   = n;
        last_rdata = rd;
        last_err   = errs;
        chk({tag, "_lat"}, 32'(last_lat), 32'(exp_lat));
        step();
        chk({tag, "_pulse"}, {31'd0, rdy}, 32'd0);
    endtask

    initial begin
        int pulses;
        int n;
        rst = 1'b1; v = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0; sel = 0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_ready", {31'd0, bus0.ready}, 32'd0);
        chk("rst_err",   {31'd0, bus0.err},   32'd0);
        chk("rst_rdata", bus0.rdata,          32'd0);
        chk("rst_ready3", {31'd0, bus3.ready}, 32'd0);

        // zero wait states: write then read back
        xfer("w_base", 0, 1'b1, BASE, 32'hDEADBEEF, 4'hF, 1);
        chk("w_base_err", {31'd0, last_err}, 32'd0);
        xfer("r_base", 0, 1'b0, BASE, 32'h0, 4'h0, 1);
        chk("r_base_data", last_rdata, 32'hDEADBEEF);
        chk("r_base_err", {31'd0, last_err}, 32'd0);

        // byte strobes
        xfer("w_b4", 0, 1'b1, BASE + 4, 32'h11223344, 4'hF, 1);
        xfer("w_b4_strb", 0, 1'b1, BASE + 4, 32'hAABBCCDD, 4'b0101, 1);
        chk("w_b4_hold", last_rdata, 32'hDEADBEEF);
        xfer("r_b4", 0, 1'b0, BASE + 4, 32'h0, 4'h0, 1);
        chk("r_b4_data", last_rdata, 32'h11BB33DD);
        xfer("w_b4_zero", 0, 1'b1, BASE + 4, 32'hFFFFFFFF, 4'h0, 1);
        chk("w_b4_zero_err", {31'd0, last_err}, 32'd0);
        xfer("r_b4b", 0, 1'b0, BASE + 6, 32'h0, 4'h0, 1);
        chk("r_b4b_data", last_rdata, 32'h11BB33DD);

        // out of range
        xfer("w_last", 0, 1'b1, TOP - 4, 32'hCAFEF00D, 4'hF, 1);
        xfer("r_top", 0, 1'b0, TOP, 32'h0, 4'h0, 1);
        chk("r_top_err", {31'd0, last_err}, 32'd1);
        chk("r_top_data", last_rdata, 32'd0);
        xfer("w_below", 0, 1'b1, BASE - 4, 32'h55555555, 4'hF, 1);
        chk("w_below_err", {31'd0, last_err}, 32'd1);
        chk("w_below_data", last_rdata, 32'd0);
        xfer("w_wrap", 0, 1'b1, 32'hFFFF_FFFC, 32'h66666666, 4'hF, 1);
        chk("w_wrap_err", {31'd0, last_err}, 32'd1);
        xfer("r_last", 0, 1'b0, TOP - 4, 32'h0, 4'h0, 1);
        chk("r_last_err", {31'd0, last_err}, 32'd0);
        chk("r_last_data", last_rdata, 32'hCAFEF00D);
        xfer("r_base2", 0, 1'b0, BASE, 32'h0, 4'h0, 1);
        chk("r_base2_data", last_rdata, 32'hDEADBEEF);

        // three wait states
        xfer("w3_a", 1, 1'b1, BASE + 8, 32'h12345678, 4'hF, 4);
        xfer("r3_a", 1, 1'b0, BASE + 8, 32'h0, 4'h0, 4);
        chk("r3_a_data", last_rdata, 32'h12345678);
        xfer("w3_b", 1, 1'b1, BASE + 12, 32'h0BADF00D, 4'hF, 4);
        chk("w3_b_hold", last_rdata, 32'h12345678);
        xfer("r3_b", 1, 1'b0, BASE + 12, 32'h0, 4'h0, 4);
        chk("r3_b_data", last_rdata, 32'h0BADF00D);
        xfer("r3_top", 1, 1'b0, TOP, 32'h0, 4'h0, 4);
        chk("r3_top_err", {31'd0, last_err}, 32'd1);
        chk("r3_top_data", last_rdata, 32'd0);

        // back-to-back with valid held high: alternating write / read-back
        pulses = 0;
        sel = 1;
        for (int i = 0; i < 8; i++) begin
            we    = (i % 2 == 0);
            addr  = BASE + 32'h20 + 32'(4 * (i / 2));
            wdata = 32'hA500_0000 + 32'(i);
            wstrb = 4'hF;
            v     = 1'b1;
            n = 0;
            do begin
                step();
                n++;
            end while (!rdy && n < 50);
            if (rdy) pulses++;
            chk("b2b_lat", 32'(n), (i == 0) ? 32'd4 : 32'd5);
            if (i % 2 == 1) chk("b2b_data", rd, 32'hA500_0000 + 32'(i - 1));
        end
        v = 1'b0;
        repeat (6) begin
            step();
            if (rdy) pulses++;
        end
        chk("b2b_pulses", 32'(pulses), 32'd8);

        // four wait states: abort by dropping valid
        xfer("w4_init", 2, 1'b1, BASE + 16, 32'h01020304, 4'hF, 5);
        sel = 2; we = 1'b1; addr = BASE + 16; wdata = 32'hFFFFFFFF; wstrb = 4'hF; v = 1'b1;
        step();
        step();
        v = 1'b0;
        pulses = 0;
        repeat (8) begin
            step();
            if (rdy) pulses++;
        end
        chk("abort_ready", 32'(pulses), 32'd0);
        xfer("r4_abort", 2, 1'b0, BASE + 16, 32'h0, 4'h0, 5);
        chk("r4_abort_data", last_rdata, 32'h01020304);

        // reset while waiting
        we = 1'b1; addr = BASE + 16; wdata = 32'hFFFFFFFF; wstrb = 4'hF; v = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        v = 1'b0;
        chk("rst_mid_ready", {31'd0, rdy}, 32'd0);
        chk("rst_mid_err", {31'd0, errs}, 32'd0);
        pulses = 0;
        repeat (8) begin
            step();
            if (rdy) pulses++;
        end
        chk("rst_mid_quiet", 32'(pulses), 32'd0);
        xfer("r4_rst", 2, 1'b0, BASE + 16, 32'h0, 4'h0, 5);
        chk("r4_rst_data", last_rdata, 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
